single_dense_layer_ctrl: RTL and testbench
==========================================

SINGLE_DENSE_LAYER_CTRL -- requirements
Module: single_dense_layer_ctrl

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 10: length of the input vector and of each weight row.
REQ-002 SHALL have parameter OUT_WIDTH, default 4: number of neurons, i.e. weight rows and output elements.
REQ-003 SHALL have parameter RELU, default 1: 1 = apply ReLU to each result, 0 = pass each result through unchanged.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to start a layer pass
- x  in  [31:0][IN_WIDTH]  input vector (IEEE-754 single), sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when all of y is valid
- y  out  [31:0][OUT_WIDTH]  registered layer outputs
- w_rd_en  out  1  weight-memory read strobe
- w_addr  out  $clog2(IN_WIDTH*OUT_WIDTH)  weight word address, row-major
- w_rd_data  in  32  weight word, valid exactly 1 cycle after w_rd_en
- dot_start  out  1  single-cycle start to the downstream dot-product unit
- dot_vector_a  out  [31:0][IN_WIDTH]  driven from the latched x
- dot_vector_b  out  [31:0][IN_WIDTH]  driven from the row buffer
- dot_done  in  1  dot-product done level; stays high until the next dot_start
- dot_c  in  32  dot-product result, valid while dot_done is high

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, DRAIN, START, WAIT, STORE and FIN.
REQ-007 IDLE: start=1 SHALL latch x into x_reg, set row r=0, set k=0, and go to FETCH; busy SHALL be 1 from the next cycle.
REQ-008 FETCH: SHALL assert w_rd_en with w_addr=r*IN_WIDTH+k for k=0..IN_WIDTH-1, one read per cycle with no gaps, then go to DRAIN.
REQ-009 SHALL capture w_rd_data into row_buf[k] in the cycle after the read of element k; the final capture occurs in DRAIN.
REQ-010 START: SHALL hold dot_start=1 for exactly one cycle, then go to WAIT.
REQ-011 WAIT: SHALL ignore dot_done in the first WAIT cycle (stale level); afterwards dot_done=1 SHALL move to STORE.
REQ-012 STORE: SHALL write y[r] from dot_c (ReLU rule applies) and leave all other y elements unchanged.
REQ-013 STORE: if r<OUT_WIDTH-1, SHALL increment r, clear k, and go to FETCH; otherwise SHALL go to FIN.
REQ-014 FIN: SHALL pulse done=1 for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-015 ReLU (RELU=1): sign=1 with non-NaN magnitude, including -0.0 (0x80000000), SHALL give 0x00000000; NaN SHALL pass unchanged; all other values SHALL pass unchanged.
REQ-016 start SHALL be ignored in every state other than IDLE; x_reg SHALL be unaffected.
REQ-017 dot_vector_a and dot_vector_b SHALL remain stable from START until STORE.
REQ-018 y SHALL hold its values after done until the next row write; a new pass overwrites y row by row.
REQ-019 Per-row latency SHALL be IN_WIDTH (FETCH) + 1 (DRAIN) + 1 (START) + WAIT length + 1 (STORE).
REQ-020 w_rd_en, dot_start and done SHALL be 0 whenever they are not asserted under REQ-008, REQ-010 and REQ-014.

Reset
REQ-021 rst=1 SHALL force IDLE and set busy=0, done=0, w_rd_en=0, w_addr=0 and dot_start=0.
REQ-022 rst=1 SHALL clear all y, x_reg and row_buf to 0, and r and k to 0.
REQ-023 rst asserted mid-pass SHALL abort the pass with no done pulse; a start after rst deasserts SHALL run a full clean pass.

Verification
REQ-024 Reset: assert rst 2 cycles -> all outputs 0, state IDLE.
REQ-025 IN=2, OUT=2, RELU=1, real dot-unit instance, x={0x3F800000, 0x40000000}, W={1.0, 1.0, -1.0, 0.0} -> w_addr sequence 0,1 then 2,3; y={0x40400000, 0x00000000}; one done pulse.
REQ-026 Same stimulus with RELU=0 -> y[1]=0xBF800000.
REQ-027 Dot-unit stub returning 0x80000000 and then 0xFFC00000 -> y[0]=0x00000000, y[1]=0xFFC00000.
REQ-028 start pulsed every cycle during a pass -> exactly one pass, w_addr never restarts early, one done pulse.
REQ-029 rst during WAIT of row 1 -> dot_start and busy low, y all 0, no done; a following start completes correctly.

Source files
------------

// File: rtl/single_dense_layer_ctrl_if.sv
// Bundles the start/result, weight-memory and dot-product-unit signals of one dense layer.
// master is the controller side; slave is the environment side.
interface single_dense_layer_ctrl_if #(
    parameter int unsigned IN_WIDTH  = 10,
    parameter int unsigned OUT_WIDTH = 4
);

    localparam int unsigned AW = (IN_WIDTH * OUT_WIDTH > 1) ? $clog2(IN_WIDTH * OUT_WIDTH) : 1;

    logic                       start;
    logic [IN_WIDTH-1:0][31:0]  x;
    logic                       busy;
    logic                       done;
    logic [OUT_WIDTH-1:0][31:0] y;

    logic                       w_rd_en;
    logic [AW-1:0]              w_addr;
    logic [31:0]                w_rd_data;

    logic                       dot_start;
    logic [IN_WIDTH-1:0][31:0]  dot_vector_a;
    logic [IN_WIDTH-1:0][31:0]  dot_vector_b;
    logic                       dot_done;
    logic [31:0]                dot_c;

    modport master (
        input  start, x, w_rd_data, dot_done, dot_c,
        output busy, done, y, w_rd_en, w_addr, dot_start, dot_vector_a, dot_vector_b
    );

    modport slave (
        output start, x, w_rd_data, dot_done, dot_c,
        input  busy, done, y, w_rd_en, w_addr, dot_start, dot_vector_a, dot_vector_b
    );

endinterface

// File: rtl/single_dense_layer_ctrl.sv
// Sequences one dense layer: streams each weight row into a buffer, launches the external
// dot-product unit once per neuron and stores the (optionally ReLU'd) result into y.
module single_dense_layer_ctrl #(
    parameter int unsigned IN_WIDTH  = 10,
    parameter int unsigned OUT_WIDTH = 4,
    parameter int unsigned RELU      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    single_dense_layer_ctrl_if.master bus
);

    localparam int unsigned AW = (IN_WIDTH * OUT_WIDTH > 1) ? $clog2(IN_WIDTH * OUT_WIDTH) : 1;
    localparam int unsigned KW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned RW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StStart,
        StWait,
        StStore,
        StFin
    } state_e;

    state_e                     state_q, state_d;
    logic [IN_WIDTH-1:0][31:0]  x_q;
    logic [IN_WIDTH-1:0][31:0]  row_q;
    logic [OUT_WIDTH-1:0][31:0] y_q;
    logic [RW-1:0]              r_q;
    logic [KW-1:0]              k_q;
    logic [KW-1:0]              cap_idx_q;
    logic                       cap_q;
    logic                       wait_first_q;
    logic                       k_last;
    logic                       r_last;

    assign k_last = (k_q == KW'(IN_WIDTH - 1));
    assign r_last = (r_q == RW'(OUT_WIDTH - 1));

    // Negative non-NaN values (including -0.0) clamp to +0.0; NaNs keep their payload.
    function automatic logic [31:0] relu_f(input logic [31:0] v);
        logic is_nan;
        is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        if ((RELU != 0) && v[31] && !is_nan) begin
            return 32'h0000_0000;
        end
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StFetch;
            StFetch: if (k_last) state_d = StDrain;
            StDrain: state_d = StStart;
            StStart: state_d = StWait;
            // dot_done may still be high from the previous row during the first WAIT cycle.
            StWait:  if (!wait_first_q && bus.dot_done) state_d = StStore;
            StStore: state_d = r_last ? StFin : StFetch;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy         = (state_q != StIdle) && (state_q != StFin);
    assign bus.done         = (state_q == StFin);
    assign bus.w_rd_en      = (state_q == StFetch);
    assign bus.w_addr       = (state_q == StFetch) ? AW'(32'(r_q) * IN_WIDTH + 32'(k_q)) : '0;
    assign bus.dot_start    = (state_q == StStart);
    assign bus.dot_vector_a = x_q;
    assign bus.dot_vector_b = row_q;
    assign bus.y            = y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            x_q          <= '0;
            row_q        <= '0;
            y_q          <= '0;
            r_q          <= '0;
            k_q          <= '0;
            cap_idx_q    <= '0;
            cap_q        <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Read data arrives one cycle after the strobe, so the buffer index trails k.
            cap_q        <= (state_q == StFetch);
            cap_idx_q    <= k_q;
            wait_first_q <= (state_q == StStart);
            if (cap_q) begin
                row_q[cap_idx_q] <= bus.w_rd_data;
            end
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        x_q <= bus.x;
                        r_q <= '0;
                        k_q <= '0;
                    end
                end
                StFetch: begin
                    if (!k_last) begin
                        k_q <= k_q + KW'(1);
                    end
                end
                StStore: begin
                    y_q[r_q] <= relu_f(bus.dot_c);
                    if (!r_last) begin
                        r_q <= r_q + RW'(1);
                        k_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_single_dense_layer_ctrl.sv
// Randomized scoreboard bench: a weight-memory model, a dot-unit stub with stale done levels,
// and a monitor comparing y of a ReLU and a pass-through instance at every done pulse.
module tb_single_dense_layer_ctrl;

    localparam int unsigned IN_W  = 2;
    localparam int unsigned OUT_W = 2;
    localparam int unsigned AW    = $clog2(IN_W * OUT_W);

    typedef logic [IN_W-1:0][31:0]  vec_t;
    typedef logic [OUT_W-1:0][31:0] yvec_t;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    single_dense_layer_ctrl_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus_r ();
    single_dense_layer_ctrl_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus_p ();

    single_dense_layer_ctrl #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .RELU(1)) dut_relu (
        .clk (clk),
        .rst (rst),
        .bus (bus_r.master)
    );

    single_dense_layer_ctrl #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .RELU(0)) dut_raw (
        .clk (clk),
        .rst (rst),
        .bus (bus_p.master)
    );

    // The pass-through instance sees exactly the same stimulus and responses.
    assign bus_p.start     = bus_r.start;
    assign bus_p.x         = bus_r.x;
    assign bus_p.w_rd_data = bus_r.w_rd_data;
    assign bus_p.dot_done  = bus_r.dot_done;
    assign bus_p.dot_c     = bus_r.dot_c;

    int checks;
    int failures;
    int done_cnt;
    int passes;

    logic [31:0]   wmem    [IN_W*OUT_W];
    logic [31:0]   res_arr [OUT_W];
    logic [AW-1:0] exp_addr_q [$];
    vec_t          exp_a_q [$];
    vec_t          exp_b_q [$];
    logic [31:0]   dot_res_q [$];
    yvec_t         exp_y_q [$];
    yvec_t         exp_raw_q [$];
    yvec_t         last_ey;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Anything with the sign bit set whose magnitude is at most +inf is a negative number.
    function automatic logic [31:0] relu_ref(input logic [31:0] v);
        logic [31:0] mag;
        mag = v & 32'h7FFF_FFFF;
        if (v >= 32'h8000_0000 && mag <= 32'h7F80_0000) return 32'h0000_0000;
        return v;
    endfunction

    function automatic logic [31:0] rand_res();
        int sel;
        sel = int'($urandom_range(0, 4));
        case (sel)
            0:       return 32'h8000_0000;
            1:       return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
            2:       return 32'hFF80_0000;
            3:       return {1'b1, 31'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Weight memory: one-cycle read latency, and checks every read address in order.
    initial begin : mem_model
        logic          pend;
        logic [AW-1:0] pend_addr;
        pend = 1'b0;
        pend_addr = '0;
        bus_r.w_rd_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus_r.w_rd_data = pend ? wmem[pend_addr] : 32'hDEAD_BEEF;
            pend = (bus_r.w_rd_en === 1'b1);
            pend_addr = bus_r.w_addr;
            if (bus_r.w_rd_en === 1'b1) begin
                check("read expected", 128'(exp_addr_q.size() != 0), 128'(1));
                if (exp_addr_q.size() != 0) begin
                    check("w_addr", 128'(bus_r.w_addr), 128'(exp_addr_q.pop_front()));
                end
            end
        end
    end

    // Dot unit stub: done stays at its old level through the first WAIT cycle, then drops for a
    // random number of cycles before the result is presented.
    initial begin : dot_model
        bit          pending;
        bit          stale;
        int          zeros;
        vec_t        ea;
        vec_t        eb;
        logic [31:0] res;
        pending = 1'b0;
        stale = 1'b0;
        zeros = 0;
        ea = '0;
        eb = '0;
        res = '0;
        bus_r.dot_done = 1'b1;
        bus_r.dot_c = 32'h3F80_0000;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pending = 1'b0;
            end else if (bus_r.dot_start === 1'b1) begin
                check("dot_start expected", 128'(exp_a_q.size() != 0), 128'(1));
                if (exp_a_q.size() != 0) begin
                    ea = exp_a_q.pop_front();
                    eb = exp_b_q.pop_front();
                    check("dot_vector_a", 128'(bus_r.dot_vector_a), 128'(ea));
                    check("dot_vector_b", 128'(bus_r.dot_vector_b), 128'(eb));
                end
                res = (dot_res_q.size() != 0) ? dot_res_q.pop_front() : 32'h0;
                pending = 1'b1;
                stale = 1'b1;
                zeros = int'($urandom_range(0, 3));
            end else if (pending) begin
                if (stale) begin
                    stale = 1'b0;
                end else if (zeros > 0) begin
                    bus_r.dot_done = 1'b0;
                    zeros--;
                end else begin
                    check("vector_a stable", 128'(bus_r.dot_vector_a), 128'(ea));
                    check("vector_b stable", 128'(bus_r.dot_vector_b), 128'(eb));
                    bus_r.dot_done = 1'b1;
                    bus_r.dot_c = res;
                    pending = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        yvec_t ey;
        yvec_t er;
        forever begin
            @(posedge clk);
            #1;
            if (bus_r.done === 1'b1) begin
                done_cnt++;
                check("done expected", 128'(exp_y_q.size() != 0), 128'(1));
                check("busy low at done", 128'(bus_r.busy), 128'(0));
                check("raw done lockstep", 128'(bus_p.done), 128'(1));
                if (exp_y_q.size() != 0) begin
                    ey = exp_y_q.pop_front();
                    er = exp_raw_q.pop_front();
                    check("y relu", 128'(bus_r.y), 128'(ey));
                    check("y raw", 128'(bus_p.y), 128'(er));
                end
            end
        end
    end

    // Issues one pass from the current wmem/res_arr; abort_row >= 0 resets in that row's WAIT.
    task automatic run_pass(input vec_t xv, input bit hammer, input int abort_row);
        yvec_t ey;
        yvec_t er;
        vec_t  b;
        vec_t  rv;
        int    cyc;
        int    dstarts;
        for (int r = 0; r < int'(OUT_W); r++) begin
            for (int k = 0; k < int'(IN_W); k++) begin
                b[k] = wmem[r * IN_W + k];
                exp_addr_q.push_back(AW'(r * IN_W + k));
            end
            exp_a_q.push_back(xv);
            exp_b_q.push_back(b);
            dot_res_q.push_back(res_arr[r]);
            ey[r] = relu_ref(res_arr[r]);
            er[r] = res_arr[r];
        end
        if (abort_row < 0) begin
            exp_y_q.push_back(ey);
            exp_raw_q.push_back(er);
            passes++;
        end
        bus_r.x = xv;
        bus_r.start = 1'b1;
        idle(1);
        check("busy after start", 128'(bus_r.busy), 128'(1));
        if (!hammer) bus_r.start = 1'b0;
        cyc = 0;
        if (abort_row >= 0) begin
            dstarts = 0;
            while (dstarts < abort_row + 1 && cyc < 200) begin
                idle(1);
                if (bus_r.dot_start === 1'b1) dstarts++;
                cyc++;
            end
            check("reached abort row", 128'(dstarts), 128'(abort_row + 1));
            idle(1);
            rst = 1'b1;
            idle(2);
            rst = 1'b0;
            check("abort busy", 128'(bus_r.busy), 128'(0));
            check("abort dot_start", 128'(bus_r.dot_start), 128'(0));
            check("abort done", 128'(bus_r.done), 128'(0));
            check("abort y relu", 128'(bus_r.y), 128'(0));
            check("abort y raw", 128'(bus_p.y), 128'(0));
            exp_addr_q.delete();
            exp_a_q.delete();
            exp_b_q.delete();
            dot_res_q.delete();
            last_ey = '0;
            return;
        end
        while (bus_r.done !== 1'b1 && cyc < 200) begin
            if (hammer) begin
                for (int k = 0; k < int'(IN_W); k++) rv[k] = $urandom;
                bus_r.x = rv;
            end
            idle(1);
            cyc++;
        end
        bus_r.start = 1'b0;
        check("pass finished in budget", 128'(bus_r.done), 128'(1));
        last_ey = ey;
    endtask

    task automatic randomize_pass(output vec_t xv);
        for (int i = 0; i < int'(IN_W * OUT_W); i++) wmem[i] = $urandom;
        for (int r = 0; r < int'(OUT_W); r++) res_arr[r] = rand_res();
        for (int k = 0; k < int'(IN_W); k++) xv[k] = $urandom;
    endtask

    initial begin : main
        vec_t xv;
        checks = 0;
        failures = 0;
        done_cnt = 0;
        passes = 0;
        last_ey = '0;
        rst = 1'b1;
        bus_r.start = 1'b0;
        bus_r.x = '0;
        idle(2);
        check("reset busy", 128'(bus_r.busy), 128'(0));
        check("reset done", 128'(bus_r.done), 128'(0));
        check("reset w_rd_en", 128'(bus_r.w_rd_en), 128'(0));
        check("reset w_addr", 128'(bus_r.w_addr), 128'(0));
        check("reset dot_start", 128'(bus_r.dot_start), 128'(0));
        check("reset y", 128'(bus_r.y), 128'(0));
        check("reset y raw", 128'(bus_p.y), 128'(0));
        check("reset vector_a", 128'(bus_r.dot_vector_a), 128'(0));
        check("reset vector_b", 128'(bus_r.dot_vector_b), 128'(0));
        rst = 1'b0;

        // x = {1.0, 2.0}, W = {1.0, 1.0; -1.0, 0.0}: the stub returns the true products 3.0, -1.0.
        wmem[0] = 32'h3F80_0000;
        wmem[1] = 32'h3F80_0000;
        wmem[2] = 32'hBF80_0000;
        wmem[3] = 32'h0000_0000;
        res_arr[0] = 32'h4040_0000;
        res_arr[1] = 32'hBF80_0000;
        xv[0] = 32'h3F80_0000;
        xv[1] = 32'h4000_0000;
        idle(1);
        run_pass(xv, 1'b0, -1);

        // -0.0 clamps, a negative quiet NaN passes through.
        res_arr[0] = 32'h8000_0000;
        res_arr[1] = 32'hFFC0_0000;
        idle(2);
        check("y holds after done", 128'(bus_r.y), 128'(last_ey));
        run_pass(xv, 1'b0, -1);

        randomize_pass(xv);
        idle(1);
        run_pass(xv, 1'b1, -1);
        idle(3);
        check("no second pass from held start", 128'(bus_r.busy), 128'(0));

        randomize_pass(xv);
        run_pass(xv, 1'b0, 1);
        randomize_pass(xv);
        idle(1);
        run_pass(xv, 1'b0, -1);

        for (int p = 0; p < 20; p++) begin
            randomize_pass(xv);
            idle(1 + int'($urandom_range(0, 3)));
            check("y holds between passes", 128'(bus_r.y), 128'(last_ey));
            run_pass(xv, ($urandom_range(0, 3) == 0), -1);
        end

        idle(4);
        check("done pulse count", 128'(done_cnt), 128'(passes));
        check("scoreboard drained", 128'(exp_y_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
